// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: datapath widths, access-size
// encodings and the request FSM state type.
package mem_stage_pkg;

  localparam int DATA_BITS = 32;
  localparam int REG_BITS  = 5;

  // funct3 encodings for loads and stores
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extractor: picks the addressed byte/halfword from a
// raw memory word and sign- or zero-extends it according to funct3.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_BITS-1:0] rdata,
  input  logic [2:0]           funct3,
  input  logic [1:0]           off,
  output logic [DATA_BITS-1:0] dm_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      LB:      dm_out = {{(DATA_BITS-8){byte_sel[7]}}, byte_sel};
      LBU:     dm_out = {{(DATA_BITS-8){1'b0}}, byte_sel};
      LH:      dm_out = {{(DATA_BITS-16){half_sel[15]}}, half_sel};
      LHU:     dm_out = {{(DATA_BITS-16){1'b0}}, half_sel};
      LW:      dm_out = rdata;
      default: dm_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory requests over a req/ready
// handshake, stalls upstream while busy, and registers the MEM/WB fields.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [DATA_BITS-1:0] ex_alu_out,
  input  logic [DATA_BITS-1:0] ex_rs2_data,
  input  logic [REG_BITS-1:0]  ex_rd_addr,
  input  logic                 ex_reg_wr,
  input  logic                 ex_mem_rd,
  input  logic                 ex_mem_wr,
  input  logic [2:0]           ex_funct3,
  output logic                 stall,
  output logic                 dm_req,
  output logic [DATA_BITS-1:0] dm_addr,
  output logic [3:0]           dm_we,
  output logic [DATA_BITS-1:0] dm_wdata,
  input  logic                 dm_ready,
  input  logic [DATA_BITS-1:0] dm_rdata,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [REG_BITS-1:0]  rd_addr,
  output logic                 reg_wr,
  output logic [DATA_BITS-1:0] dm_out,
  output logic                 dm2reg
);

  mem_state_t           state, state_nxt;
  logic                 mop;
  logic                 is_load;
  logic [1:0]           off, off_q;
  logic [2:0]           funct3_q;
  logic [3:0]           we_nxt;
  logic [DATA_BITS-1:0] wdata_nxt;
  logic [DATA_BITS-1:0] load_data;

  assign mop     = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign is_load = ex_valid & ex_mem_rd;
  assign off     = ex_alu_out[1:0];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mop)      state_nxt = ST_BUSY;
      ST_BUSY: if (dm_ready) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      ST_IDLE: stall = mop;
      ST_BUSY: stall = ~dm_ready;
      default: stall = 1'b0;
    endcase
  end

  // Store lane steering; loads leave the byte enables and data at zero.
  always_comb begin
    we_nxt    = 4'b0000;
    wdata_nxt = '0;
    if (ex_mem_wr) begin
      case (ex_funct3)
        SB: begin
          we_nxt    = 4'b0001 << off;
          wdata_nxt = ex_rs2_data << {off, 3'b000};
        end
        SH: begin
          we_nxt    = 4'b0011 << {off[1], 1'b0};
          wdata_nxt = ex_rs2_data << {off[1], 4'b0000};
        end
        SW: begin
          we_nxt    = 4'b1111;
          wdata_nxt = ex_rs2_data;
        end
        default: begin
          we_nxt    = 4'b1111;
          wdata_nxt = ex_rs2_data;
        end
      endcase
    end
  end

  // Request registers; offset and size are kept for extracting the load reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_addr  <= '0;
      dm_we    <= 4'b0000;
      dm_wdata <= '0;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
    end else if (state == ST_IDLE && mop) begin
      dm_req   <= 1'b1;
      dm_addr  <= {ex_alu_out[DATA_BITS-1:2], 2'b00};
      dm_we    <= we_nxt;
      dm_wdata <= wdata_nxt;
      off_q    <= off;
      funct3_q <= ex_funct3;
    end else if (state == ST_BUSY && dm_ready) begin
      dm_req   <= 1'b0;
    end
  end

  load_align u_load_align (
    .rdata  (dm_rdata),
    .funct3 (funct3_q),
    .off    (off_q),
    .dm_out (load_data)
  );

  // MEM/WB register: a stalled cycle writes a bubble.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      rd_data <= '0;
      rd_addr <= '0;
      reg_wr  <= 1'b0;
      dm_out  <= '0;
      dm2reg  <= 1'b0;
    end else begin
      rd_data <= ex_alu_out;
      rd_addr <= ex_rd_addr;
      reg_wr  <= ex_valid & ex_reg_wr;
      dm_out  <= is_load ? load_data : '0;
      dm2reg  <= is_load;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops
// against a transaction-level model, and back-to-back / reset-in-busy cases.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [31:0] ex_alu_out, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic        stall, dm_req, dm_ready, reg_wr, dm2reg;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, rd_data, dm_out;
  logic [3:0]  dm_we;
  logic [4:0]  rd_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd_addr  (ex_rd_addr),
    .ex_reg_wr   (ex_reg_wr),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_wr   (ex_mem_wr),
    .ex_funct3   (ex_funct3),
    .stall       (stall),
    .dm_req      (dm_req),
    .dm_addr     (dm_addr),
    .dm_we       (dm_we),
    .dm_wdata    (dm_wdata),
    .dm_ready    (dm_ready),
    .dm_rdata    (dm_rdata),
    .rd_data     (rd_data),
    .rd_addr     (rd_addr),
    .reg_wr      (reg_wr),
    .dm_out      (dm_out),
    .dm2reg      (dm2reg)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  f3;
    int          waits;
    logic [31:0] rdata;
    logic        chk_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dm_out;
    int          exp_stalls;
    logic        exp_reg_wr;
    logic        exp_dm2reg;
  } op_t;

  bit log_en = 1'b0;
  bit req_log[$];
  always @(negedge clk) if (log_en) req_log.push_back(dm_req);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] w);
    longint v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic op_t model(input op_t o);
    int unsigned off = o.alu_out % 4;
    bit          mop = o.valid && (o.mem_rd || o.mem_wr);
    o.chk_req    = mop;
    o.exp_stalls = mop ? 1 + o.waits : 0;
    o.exp_reg_wr = o.valid & o.reg_wr;
    o.exp_dm2reg = o.valid & o.mem_rd;
    o.exp_addr   = o.alu_out - off;
    o.exp_we     = 4'h0;
    o.exp_wdata  = 32'h0;
    if (o.mem_wr) begin
      case (o.f3)
        3'd0: begin o.exp_we = 4'(1 << off);             o.exp_wdata = o.rs2 << (8 * off); end
        3'd1: begin o.exp_we = 4'(3 << (2 * (off / 2))); o.exp_wdata = o.rs2 << (16 * (off / 2)); end
        default: begin o.exp_we = 4'hF;                  o.exp_wdata = o.rs2; end
      endcase
    end
    o.exp_dm_out = (o.valid && o.mem_rd) ? ref_load(o.f3, off, o.rdata) : 32'h0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t        o;
    int         kind = $urandom_range(0, 2);
    logic [2:0] lf[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    o.valid   = ($urandom_range(0, 7) != 0);
    o.alu_out = $urandom;
    o.rs2     = $urandom;
    o.rd      = 5'($urandom);
    o.reg_wr  = 1'($urandom);
    o.rdata   = $urandom;
    o.waits   = $urandom_range(0, 3);
    o.mem_rd  = (kind == 1);
    o.mem_wr  = (kind == 2);
    case (kind)
      1:       o.f3 = lf[$urandom_range(0, 4)];
      2:       o.f3 = 3'($urandom_range(0, 2));
      default: o.f3 = 3'($urandom);
    endcase
    return model(o);
  endfunction

  // Present one instruction, serve the memory handshake, then check MEM/WB.
  task automatic apply(input op_t o, input string tag);
    int          stalls = 0, req_cyc = 0, w = 0, cyc = 0;
    bit          done = 1'b0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
    logic [3:0]  c_we = 4'h0;
    ex_valid    = o.valid;
    ex_alu_out  = o.alu_out;
    ex_rs2_data = o.rs2;
    ex_rd_addr  = o.rd;
    ex_reg_wr   = o.reg_wr;
    ex_mem_rd   = o.mem_rd;
    ex_mem_wr   = o.mem_wr;
    ex_funct3   = o.f3;
    dm_rdata    = o.rdata;
    dm_ready    = 1'b0;
    while (!done && cyc < 40) begin
      if (dm_req) begin
        req_cyc++;
        c_addr  = dm_addr;
        c_we    = dm_we;
        c_wdata = dm_wdata;
        if (w == o.waits) dm_ready = 1'b1;
        else begin dm_ready = 1'b0; w++; end
      end else begin
        dm_ready = 1'b0;
      end
      @(negedge clk);
      if (stall) stalls++;
      else       done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    dm_ready = 1'b0;
    ex_valid = 1'b0;
    check({tag, ".completed"}, 32'(done), 32'd1);
    check({tag, ".stall_cycles"}, stalls, o.exp_stalls);
    check({tag, ".req_cycles"}, req_cyc, o.exp_stalls);
    check({tag, ".rd_data"}, rd_data, o.alu_out);
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(o.rd));
    check({tag, ".reg_wr"}, 32'(reg_wr), 32'(o.exp_reg_wr));
    check({tag, ".dm2reg"}, 32'(dm2reg), 32'(o.exp_dm2reg));
    check({tag, ".dm_out"}, dm_out, o.exp_dm_out);
    if (o.chk_req) begin
      check({tag, ".dm_addr"}, c_addr, o.exp_addr);
      check({tag, ".dm_we"}, 32'(c_we), 32'(o.exp_we));
      if (o.mem_wr) check({tag, ".dm_wdata"}, c_wdata, o.exp_wdata);
    end
  endtask

  op_t tbl[10];

  initial begin
    //          valid  alu_out       rs2           rd     reg_wr mem_rd mem_wr f3      waits rdata
    //          chk    exp_addr      exp_we   exp_wdata     exp_dm_out    stalls reg_wr dm2reg
    tbl[0] = '{1'b1, 32'h0000_1234, 32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 3'b000, 0, 32'h0,
               1'b0, 32'h0,         4'h0,    32'h0,        32'h0,        0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 2, 32'h0,
               1'b1, 32'h0000_0100, 4'b1000, 32'hAB00_0000, 32'h0,        3, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0102, 32'h0,        5'd7,  1'b1, 1'b1, 1'b0, 3'b000, 0, 32'h0080_0000,
               1'b1, 32'h0000_0100, 4'h0,    32'h0,        32'hFFFF_FF80, 1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_0102, 32'h0,        5'd8,  1'b1, 1'b1, 1'b0, 3'b100, 0, 32'h0080_0000,
               1'b1, 32'h0000_0100, 4'h0,    32'h0,        32'h0000_0080, 1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0202, 32'h0,        5'd9,  1'b1, 1'b1, 1'b0, 3'b001, 1, 32'h8001_7FFF,
               1'b1, 32'h0000_0200, 4'h0,    32'h0,        32'hFFFF_8001, 2, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 32'h0000_0202, 32'h0,        5'd10, 1'b1, 1'b1, 1'b0, 3'b101, 0, 32'h8001_7FFF,
               1'b1, 32'h0000_0200, 4'h0,    32'h0,        32'h0000_8001, 1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_0202, 32'h0,        5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 3, 32'h8001_7FFF,
               1'b1, 32'h0000_0200, 4'h0,    32'h0,        32'h8001_7FFF, 4, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_0055, 32'h0,        5'd9,  1'b1, 1'b1, 1'b0, 3'b010, 0, 32'h0000_FFFF,
               1'b0, 32'h0,         4'h0,    32'h0,        32'h0,        0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'h0000_00F2, 32'h1234_BEEF, 5'd1, 1'b0, 1'b0, 1'b1, 3'b001, 1, 32'h0,
               1'b1, 32'h0000_00F0, 4'b1100, 32'hBEEF_0000, 32'h0,        2, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 5'd2, 1'b0, 1'b0, 1'b1, 3'b010, 0, 32'h0,
               1'b1, 32'h0000_0044, 4'hF,    32'hDEAD_BEEF, 32'h0,        1, 1'b0, 1'b0};

    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_out = 32'h0; ex_rs2_data = 32'h0; ex_rd_addr = 5'd0;
    ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_funct3 = 3'b000;
    dm_ready = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset.dm_req", 32'(dm_req), 32'd0);
    check("reset.dm_we", 32'(dm_we), 32'd0);
    check("reset.dm_addr", dm_addr, 32'h0);
    check("reset.dm_wdata", dm_wdata, 32'h0);
    check("reset.wb", {rd_data[15:0], 8'(rd_addr), 6'd0, reg_wr, dm2reg}, 32'h0);
    check("reset.dm_out", dm_out, 32'h0);
    check("reset.stall", 32'(stall), 32'd0);

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) apply(rand_op(), $sformatf("rand%0d", i));

    // Back-to-back loads: one idle request cycle between the two pulses.
    begin
      op_t a, b;
      int  pulses = 0, gap = -1, zeros = 0;
      bit  prev = 1'b0;
      a = tbl[6]; a.waits = 1; a.rd = 5'd20; a.alu_out = 32'h0000_0400; a.rdata = 32'h1111_2222;
      b = tbl[6]; b.waits = 1; b.rd = 5'd21; b.alu_out = 32'h0000_0404; b.rdata = 32'h3333_4444;
      a = model(a);
      b = model(b);
      req_log.delete();
      log_en = 1'b1;
      apply(a, "b2b_first");
      apply(b, "b2b_second");
      log_en = 1'b0;
      foreach (req_log[i]) begin
        if (req_log[i] && !prev) begin
          pulses++;
          if (pulses == 2) gap = zeros;
        end
        if (req_log[i]) zeros = 0;
        else            zeros++;
        prev = req_log[i];
      end
      check("b2b.pulses", pulses, 2);
      check("b2b.idle_gap", gap, 1);
    end

    // Reset while BUSY abandons the request; a late ready is then ignored.
    ex_valid = 1'b1; ex_alu_out = 32'h0000_0300; ex_rd_addr = 5'd12; ex_reg_wr = 1'b1;
    ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_funct3 = 3'b010; dm_ready = 1'b0;
    dm_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("rstbusy.req_up", 32'(dm_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstbusy.dm_req", 32'(dm_req), 32'd0);
    check("rstbusy.wb", {rd_data[15:0], 8'(rd_addr), 6'd0, reg_wr, dm2reg}, 32'h0);
    check("rstbusy.dm_out", dm_out, 32'h0);
    dm_ready = 1'b1;
    @(negedge clk);
    check("rstbusy.idle_stall", 32'(stall), 32'd1);
    ex_valid = 1'b0;
    #1;
    check("rstbusy.bubble_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dm_ready = 1'b0;
    check("rstbusy.late_ready_req", 32'(dm_req), 32'd0);
    check("rstbusy.late_ready_wr", 32'(reg_wr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, sitting between the EX/MEM register and the MEM/WB register. It drives the `inf_MEM_WB` producer side. It issues load/store requests to the data-memory port through a two-state request/ready handshake, stalls upstream while a request is outstanding, and byte-aligns and sign/zero-extends load data. It then registers `rd_data`, `rd_addr`, `reg_wr`, `dm_out` and `dm2reg` for write-back.

## Interface
- `DATA_BITS`, 32, datapath width (from CPU_def)
- `REG_BITS`, 5, register-index width (from CPU_def)
- `clk  in  1` – single clock; all state updates on rising edge
- `rst  in  1` – synchronous, active-high reset
- `ex_valid  in  1` – EX/MEM holds a valid instruction
- `ex_alu_out  in  DATA_BITS` – ALU result / effective address
- `ex_rs2_data  in  DATA_BITS` – store data
- `ex_rd_addr  in  REG_BITS` – destination register
- `ex_reg_wr  in  1` – instruction writes rd
- `ex_mem_rd`, `ex_mem_wr  in  1` – load / store (never both)
- `ex_funct3  in  3` – access size/sign
- `stall  out  1` – freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- `dm_req  out  1` – data-memory request valid (registered)
- `dm_addr  out  DATA_BITS` – word-aligned address ({addr[31:2],2'b00})
- `dm_we  out  4` – active-high byte write enables; 0 for loads
- `dm_wdata  out  DATA_BITS` – lane-shifted store data
- `dm_ready  in  1` – request accepted/completed this cycle
- `dm_rdata  in  DATA_BITS` – raw read word, valid when `dm_ready`
- `MEM2WB` modport of `inf_MEM_WB` – outputs `rd_data`, `rd_addr`, `reg_wr`, `dm_out`, `dm2reg`

## Operation
- Memory op: `mop = ex_valid & (ex_mem_rd | ex_mem_wr)`.
- FSM has two states. **IDLE**: if `mop`, latch the address, `dm_we` and `dm_wdata` into the request registers, set `dm_req`=1 and go to BUSY. **BUSY**: hold the request. On `dm_ready`, clear `dm_req` and return to IDLE.
- `stall = (IDLE & mop) | (BUSY & ~dm_ready)` (combinational).
- Lanes use `off = ex_alu_out[1:0]`.
  - SB (000): `we = 4'b0001<<off`.
  - SH (001): `we = 4'b0011<<{off[1],1'b0}`.
  - SW (010): `we = 4'b1111`.
  - `wdata = rs2 << 8*off` for SB, `rs2 << 16*off[1]` for SH, and unshifted `rs2` for SW.
  - Misalignment is not trapped. Low bits below the access size are ignored.
- Load extraction from `dm_rdata`, using the offset latched at request time:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the halfword at `off[1]`.
  - LHU (101): zero-extend that halfword.
  - LW (010): whole word.
- MEM/WB register update every cycle:
  - While `stall`=1, load a bubble: `reg_wr`=0, `dm2reg`=0, other fields don't-care (driven 0).
  - Otherwise load `rd_data=ex_alu_out`, `rd_addr=ex_rd_addr`, `reg_wr=ex_valid&ex_reg_wr`, `dm2reg=ex_valid&ex_mem_rd`, and `dm_out` = extracted load data (0 for non-loads).
- `ex_valid`=0 produces a bubble with no request.

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` all 0; all MEM2WB outputs 0. `stall` follows its equation from reset state and inputs.
- Non-memory instruction: 1-cycle latency to MEM2WB, no stall.
- Memory op, with cycle 0 as the first cycle it is presented:
  - Cycle 0 is IDLE, with `stall`=1 and `dm_req` rising at the end of the cycle.
  - In cycle 1+k, `dm_ready` arrives after k wait cycles.
  - In that `dm_ready` cycle, `stall`=0. MEM2WB captures the result at that edge and EX/MEM advances at the same edge.
  - Minimum 2 cycles; `stall` high for 1+k cycles.
- Upstream must hold all `ex_*` inputs stable while `stall`=1.
- `dm_ready` outside BUSY is ignored.
- Back-to-back memory ops: the second op sees IDLE in the cycle after completion, so there is one idle request cycle between them.
- `rst` in BUSY: the request is abandoned, and `dm_req` is 0 in the next cycle. The memory side must tolerate dropped requests.

## Structure
- Access-size encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) and the FSM state enum go in the shared CPU package beside the `CPU_def` constants.
- One sub-module, `load_align`: combinational `(rdata, funct3, off) -> dm_out`. It is reused by any future load-forwarding path.

## Test plan
- ALU op `ex_alu_out`=0x1234, `rd`=5, `reg_wr`=1 -> next cycle `rd_data`=0x1234, `rd_addr`=5, `reg_wr`=1, `dm2reg`=0, no stall.
- SB at addr 0x103, `rs2`=0xAB, `dm_ready` after 2 waits -> `dm_addr`=0x100, `dm_we`=4'b1000, `dm_wdata`=0xAB000000; `stall` high 3 cycles; MEM2WB `reg_wr`=0.
- LB at 0x102 with `dm_rdata`=0x0080_0000, immediate ready -> `dm_out`=0xFFFFFF80, `dm2reg`=1; the LBU variant gives 0x00000080.
- LH at 0x202 with `rdata`=0x8001_7FFF -> `dm_out`=0xFFFF8001; LHU gives 0x00008001; LW gives 0x80017FFF.
- Two back-to-back LWs -> exactly one idle cycle between `dm_req` pulses, and both results written in order.
- `rst` asserted in BUSY -> next cycle `dm_req`=0, state IDLE, all MEM2WB outputs 0, and a late `dm_ready` is ignored.
